m_row_aligner: RTL and testbench

- Parametrised successor to the F-value/vinput alignment stage that feeds the MAC.
- Accepts one serial F-value stream, demultiplexed across A channel FIFOs by a set counter, plus one vinput stream.
- Emits fully aligned beats {A F-values, one vinput, last} to the MAC.
- Adds what the previous stage lacked: ready/valid backpressure on every interface, a registered output stage, per-channel set-length checking and sticky error flags.

---
 rtl/m_row_pkg.sv | 11 +
 rtl/m_row_aligner_if.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 53 +++++
 rtl/m_row_aligner.sv | 156 +++++++++++++++
 tb/tb_m_row_aligner.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m_row_pkg.sv
// Shared defaults for the F-value/vinput row aligner and its FIFOs.
package m_row_pkg;

    localparam int unsigned DW_DEF    = 64;
    localparam int unsigned A_DEF     = 2;
    localparam int unsigned LW_DEF    = 16;
    localparam int unsigned PTR_W     = 9;
    localparam int unsigned DEPTH_DEF = 1 << PTR_W;
    localparam int unsigned CH_W      = $clog2(A_DEF) + 1;

endpackage

// File: rtl/m_row_aligner_if.sv
// Handshake bundle between the F/vinput producers, the aligner and the MAC.
interface m_row_aligner_if
    import m_row_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned A  = A_DEF
);

    logic [DW-1:0]   f_data;
    logic            f_valid;
    logic            f_last;
    logic            f_ready;
    logic [DW-1:0]   v_data;
    logic            v_valid;
    logic            v_ready;
    logic [A*DW-1:0] m_row;
    logic [DW-1:0]   m_vinput;
    logic            m_last;
    logic            m_valid;
    logic            m_ready;

    modport master (
        output f_data, f_valid, f_last, v_data, v_valid, m_ready,
        input  f_ready, v_ready, m_row, m_vinput, m_last, m_valid
    );

    modport slave (
        input  f_data, f_valid, f_last, v_data, v_valid, m_ready,
        output f_ready, v_ready, m_row, m_vinput, m_last, m_valid
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a written entry becomes readable one cycle after its write edge.
module sync_fifo_fwft
    import m_row_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF + 1,
    parameter int unsigned DEPTH = 1 << PTR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DW-1:0]            din,
    input  logic                     rd_en,
    output logic [DW-1:0]            dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_vis;
    logic [PW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (rd_ptr == wr_ptr_vis);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Read side sees the write pointer one edge late, giving the extra cycle of fall-through.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
        end else begin
            wr_ptr_vis <= wr_ptr;
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/m_row_aligner.sv
// Demultiplexes an F-value stream into A channel FIFOs, joins them with vinput and
// presents registered aligned rows to the MAC, with set-length and overflow flags.
module m_row_aligner
    import m_row_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned A     = A_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned LW    = LW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    m_row_aligner_if.slave         bus,
    output logic [$clog2(A):0]     ch_sel,
    output logic                   len_err,
    output logic                   ovf_err,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned SEL_W = $clog2(A) + 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned EW    = DW + 1;

    logic [EW-1:0]    ch_dout  [A];
    logic [LVL_W-1:0] ch_count [A];
    logic [A-1:0]     ch_empty;
    logic [A-1:0]     ch_full;
    logic [A-1:0]     ch_wr;
    logic [DW-1:0]    v_dout;
    logic [LVL_W-1:0] v_count;
    logic             v_empty;
    logic             v_full;

    logic [LW-1:0]    cnt [A];
    logic [LW-1:0]    ref_len;
    logic [LW-1:0]    sel_cnt_inc_c;
    logic [LW-1:0]    sel_cnt_c;
    logic             sel_full_c;
    logic             f_acc_c;
    logic             v_acc_c;
    logic             pop_c;
    logic             unused_sink;

    logic [A*DW-1:0]  row_q;
    logic [DW-1:0]    vin_q;
    logic             last_q;
    logic             valid_q;

    // State of the channel currently addressed by ch_sel.
    always_comb begin
        sel_full_c = 1'b0;
        sel_cnt_c  = '0;
        for (int a = 0; a < A; a++) begin
            if (ch_sel == SEL_W'(a)) begin
                sel_full_c = ch_full[a];
                sel_cnt_c  = cnt[a];
            end
        end
    end

    assign sel_cnt_inc_c = sel_cnt_c + LW'(1);
    assign f_acc_c       = bus.f_valid && !sel_full_c;
    assign v_acc_c       = bus.v_valid && !v_full;
    assign pop_c         = (&(~ch_empty)) && !v_empty && (!valid_q || bus.m_ready);

    assign bus.f_ready   = !sel_full_c;
    assign bus.v_ready   = !v_full;
    assign bus.m_row     = row_q;
    assign bus.m_vinput  = vin_q;
    assign bus.m_last    = last_q;
    assign bus.m_valid   = valid_q;

    for (genvar a = 0; a < A; a++) begin : g_ch
        assign ch_wr[a] = f_acc_c && (ch_sel == SEL_W'(a));

        sync_fifo_fwft #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (ch_wr[a]),
            .din   ({bus.f_last, bus.f_data}),
            .rd_en (pop_c),
            .dout  (ch_dout[a]),
            .empty (ch_empty[a]),
            .full  (ch_full[a]),
            .count (ch_count[a])
        );
    end

    sync_fifo_fwft #(.DW(DW), .DEPTH(DEPTH)) u_vfifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (v_acc_c),
        .din   (bus.v_data),
        .rd_en (pop_c),
        .dout  (v_dout),
        .empty (v_empty),
        .full  (v_full),
        .count (v_count)
    );

    // Last bits of channels above 0 and their counts are not consumed downstream.
    always_comb begin
        unused_sink = ^v_count;
        for (int a = 1; a < A; a++) begin
            unused_sink = unused_sink ^ ch_dout[a][DW] ^ (^ch_count[a]);
        end
    end

    // Channel select, set-length tracking and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_sel  <= '0;
            ref_len <= '0;
            len_err <= 1'b0;
            ovf_err <= 1'b0;
            for (int a = 0; a < A; a++) cnt[a] <= '0;
        end else begin
            if (f_acc_c) begin
                for (int a = 0; a < A; a++) begin
                    if (ch_sel == SEL_W'(a)) cnt[a] <= bus.f_last ? '0 : sel_cnt_inc_c;
                end
                if (bus.f_last) begin
                    ch_sel <= (ch_sel == SEL_W'(A - 1)) ? '0 : ch_sel + SEL_W'(1);
                    if (ch_sel == '0) begin
                        ref_len <= sel_cnt_inc_c;
                    end else if (sel_cnt_inc_c != ref_len) begin
                        len_err <= 1'b1;
                    end
                end
            end
            if ((bus.f_valid && sel_full_c) || (bus.v_valid && v_full)) ovf_err <= 1'b1;
        end
    end

    // Output register: loads on join, holds while stalled, drains when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            vin_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            level   <= '0;
        end else begin
            level <= ch_count[0];
            if (pop_c) begin
                for (int a = 0; a < A; a++) row_q[a*DW +: DW] <= ch_dout[a][DW-1:0];
                vin_q   <= v_dout;
                last_q  <= ch_dout[0][DW];
                valid_q <= 1'b1;
            end else if (bus.m_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m_row_aligner.sv
// Directed bench for m_row_aligner: a 2-channel/depth-8 and a 3-channel/depth-4 instance.
module tb_m_row_aligner;
    import m_row_pkg::*;

    localparam int unsigned TDW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    m_row_aligner_if #(.DW(TDW), .A(2)) b0 ();
    m_row_aligner_if #(.DW(TDW), .A(3)) b1 ();

    logic [CH_W-1:0] ch_sel0;
    logic [3:0]      level0;
    logic            len_err0;
    logic            ovf_err0;
    logic [2:0]      ch_sel1;
    logic [2:0]      level1;
    logic            len_err1;
    logic            ovf_err1;

    m_row_aligner #(.DW(TDW), .A(2), .DEPTH(8), .LW(8)) dut0 (
        .clk(clk), .rst(rst), .bus(b0),
        .ch_sel(ch_sel0), .len_err(len_err0), .ovf_err(ovf_err0), .level(level0)
    );

    m_row_aligner #(.DW(TDW), .A(3), .DEPTH(4), .LW(8)) dut1 (
        .clk(clk), .rst(rst), .bus(b1),
        .ch_sel(ch_sel1), .len_err(len_err1), .ovf_err(ovf_err1), .level(level1)
    );

    typedef struct {
        logic [63:0] row;
        logic [15:0] vin;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (b0.m_valid && b0.m_ready) q0.push_back('{row: 64'(b0.m_row), vin: b0.m_vinput, last: b0.m_last});
        if (b1.m_valid && b1.m_ready) q1.push_back('{row: 64'(b1.m_row), vin: b1.m_vinput, last: b1.m_last});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic push_f0(input logic [15:0] d, input logic l);
        int n = 0;
        b0.f_data = d; b0.f_last = l; b0.f_valid = 1'b1;
        @(negedge clk);
        while (!b0.f_ready && n < 50) begin @(negedge clk); n++; end
        chk("f0_ready", 64'(b0.f_ready), 64'd1);
        @(posedge clk);
        #1;
        b0.f_valid = 1'b0; b0.f_last = 1'b0;
    endtask

    task automatic push_v0(input logic [15:0] d);
        int n = 0;
        b0.v_data = d; b0.v_valid = 1'b1;
        @(negedge clk);
        while (!b0.v_ready && n < 50) begin @(negedge clk); n++; end
        chk("v0_ready", 64'(b0.v_ready), 64'd1);
        @(posedge clk);
        #1;
        b0.v_valid = 1'b0;
    endtask

    task automatic push_f1(input logic [15:0] d, input logic l);
        int n = 0;
        b1.f_data = d; b1.f_last = l; b1.f_valid = 1'b1;
        @(negedge clk);
        while (!b1.f_ready && n < 50) begin @(negedge clk); n++; end
        chk("f1_ready", 64'(b1.f_ready), 64'd1);
        @(posedge clk);
        #1;
        b1.f_valid = 1'b0; b1.f_last = 1'b0;
    endtask

    task automatic push_v1(input logic [15:0] d);
        int n = 0;
        b1.v_data = d; b1.v_valid = 1'b1;
        @(negedge clk);
        while (!b1.v_ready && n < 50) begin @(negedge clk); n++; end
        chk("v1_ready", 64'(b1.v_ready), 64'd1);
        @(posedge clk);
        #1;
        b1.v_valid = 1'b0;
    endtask

    task automatic wait_valid0(input string tag);
        int n = 0;
        while (!b0.m_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk(tag, 64'(b0.m_valid), 64'd1);
    endtask

    task automatic chk_beat0(input string tag, input int i, input logic [63:0] row,
                             input logic [15:0] vin, input logic last);
        if (q0.size() > i) begin
            chk({tag, "_row"}, q0[i].row, row);
            chk({tag, "_vin"}, 64'(q0[i].vin), 64'(vin));
            chk({tag, "_last"}, 64'(q0[i].last), 64'(last));
        end
    endtask

    initial begin
        b0.f_data = '0; b0.f_valid = 1'b0; b0.f_last = 1'b0;
        b0.v_data = '0; b0.v_valid = 1'b0; b0.m_ready = 1'b1;
        b1.f_data = '0; b1.f_valid = 1'b0; b1.f_last = 1'b0;
        b1.v_data = '0; b1.v_valid = 1'b0; b1.m_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_valid", 64'(b0.m_valid), 64'd0);
        chk("rst_row", 64'(b0.m_row), 64'd0);
        chk("rst_fready", 64'(b0.f_ready), 64'd1);
        chk("rst_vready", 64'(b0.v_ready), 64'd1);
        chk("rst_chsel", 64'(ch_sel0), 64'd0);
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_errs", 64'({len_err0, ovf_err0}), 64'd0);

        // Basic alignment and join latency
        push_f0(16'd1, 1'b0); push_f0(16'd2, 1'b0); push_f0(16'd3, 1'b1);
        chk("s1_chsel1", 64'(ch_sel0), 64'd1);
        push_f0(16'd4, 1'b0); push_f0(16'd5, 1'b0); push_f0(16'd6, 1'b1);
        chk("s1_chsel0", 64'(ch_sel0), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        chk("s1_novin", 64'(b0.m_valid), 64'd0);
        push_v0(16'd10);
        chk("lat_t0", 64'(b0.m_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_t1", 64'(b0.m_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_t2", 64'(b0.m_valid), 64'd1);
        chk("lat_row", 64'(b0.m_row), 64'h0004_0001);
        push_v0(16'd11); push_v0(16'd12);
        repeat (8) begin @(posedge clk); #1; end
        chk("s1_n", 64'(q0.size()), 64'd3);
        chk_beat0("s1_b0", 0, 64'h0004_0001, 16'd10, 1'b0);
        chk_beat0("s1_b1", 1, 64'h0005_0002, 16'd11, 1'b0);
        chk_beat0("s1_b2", 2, 64'h0006_0003, 16'd12, 1'b1);
        chk("s1_lenerr", 64'(len_err0), 64'd0);
        chk("s1_level", 64'(level0), 64'd0);

        // Backpressure: output holds while m_ready is low
        do_reset();
        b0.m_ready = 1'b0;
        push_f0(16'd1, 1'b0); push_f0(16'd2, 1'b0); push_f0(16'd3, 1'b1);
        push_f0(16'd4, 1'b0); push_f0(16'd5, 1'b0); push_f0(16'd6, 1'b1);
        push_v0(16'd10); push_v0(16'd11); push_v0(16'd12);
        wait_valid0("bp_valid");
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_hold_v", 64'(b0.m_valid), 64'd1);
        chk("bp_hold_row", 64'(b0.m_row), 64'h0004_0001);
        chk("bp_hold_vin", 64'(b0.m_vinput), 64'd10);
        chk("bp_none", 64'(q0.size()), 64'd0);
        chk("bp_level", 64'(level0), 64'd2);
        b0.m_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("bp_n", 64'(q0.size()), 64'd3);
        chk_beat0("bp_b0", 0, 64'h0004_0001, 16'd10, 1'b0);
        chk_beat0("bp_b1", 1, 64'h0005_0002, 16'd11, 1'b0);
        chk_beat0("bp_b2", 2, 64'h0006_0003, 16'd12, 1'b1);

        // Set-length mismatch, data keeps flowing
        do_reset();
        push_f0(16'd1, 1'b0); push_f0(16'd2, 1'b0); push_f0(16'd3, 1'b1);
        chk("len_ok", 64'(len_err0), 64'd0);
        push_f0(16'd4, 1'b0); push_f0(16'd5, 1'b1);
        chk("len_err", 64'(len_err0), 64'd1);
        push_v0(16'd10); push_v0(16'd11);
        repeat (8) begin @(posedge clk); #1; end
        chk("len_n", 64'(q0.size()), 64'd2);
        chk_beat0("len_b0", 0, 64'h0004_0001, 16'd10, 1'b0);
        chk_beat0("len_b1", 1, 64'h0005_0002, 16'd11, 1'b0);
        chk("len_level", 64'(level0), 64'd1);

        // Reset mid-stream discards buffered data and clears sticky errors
        b0.m_ready = 1'b0;
        push_f0(16'd7, 1'b1); push_f0(16'd8, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_level", 64'(level0), 64'd2);
        do_reset();
        chk("mid_valid", 64'(b0.m_valid), 64'd0);
        chk("mid_row", 64'(b0.m_row), 64'd0);
        chk("mid_level0", 64'(level0), 64'd0);
        chk("mid_chsel", 64'(ch_sel0), 64'd0);
        chk("mid_errs", 64'({len_err0, ovf_err0}), 64'd0);
        b0.m_ready = 1'b1;
        push_v0(16'd10);
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_stale", 64'(q0.size()), 64'd0);
        chk("mid_nvalid", 64'(b0.m_valid), 64'd0);

        // Full channel FIFO (depth 4) and overflow flag
        do_reset();
        push_f1(16'd1, 1'b0); push_f1(16'd2, 1'b0); push_f1(16'd3, 1'b0); push_f1(16'd4, 1'b0);
        chk("full_fready", 64'(b1.f_ready), 64'd0);
        @(posedge clk); #1;
        chk("full_level", 64'(level1), 64'd4);
        chk("full_noovf", 64'(ovf_err1), 64'd0);
        b1.f_data = 16'd5; b1.f_valid = 1'b1;
        @(posedge clk); #1;
        chk("full_ovf", 64'(ovf_err1), 64'd1);
        b1.f_valid = 1'b0;
        @(posedge clk); #1;
        chk("full_level2", 64'(level1), 64'd4);
        chk("full_chsel", 64'(ch_sel1), 64'd0);

        // Channel select wrap-around with three channels
        do_reset();
        push_f1(16'd1, 1'b1);
        chk("wrap_sel1", 64'(ch_sel1), 64'd1);
        push_f1(16'd2, 1'b1);
        chk("wrap_sel2", 64'(ch_sel1), 64'd2);
        push_f1(16'd3, 1'b1);
        chk("wrap_sel0", 64'(ch_sel1), 64'd0);
        push_f1(16'd4, 1'b1);
        chk("wrap_sel1b", 64'(ch_sel1), 64'd1);
        push_v1(16'd10);
        repeat (6) begin @(posedge clk); #1; end
        chk("wrap_n", 64'(q1.size()), 64'd1);
        if (q1.size() > 0) begin
            chk("wrap_row", q1[0].row, 64'h0003_0002_0001);
            chk("wrap_vin", 64'(q1[0].vin), 64'd10);
            chk("wrap_last", 64'(q1[0].last), 64'd1);
        end
        chk("wrap_level", 64'(level1), 64'd1);
        chk("wrap_lenerr", 64'(len_err1), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
